// File: rtl/bp_l15_transducer_pkg.sv
// rtl/bp_l15_transducer_pkg.sv - shared types, L1.5 encodings and helpers for the BP/L1.5 transducer
package bp_l15_transducer_pkg;

    typedef enum logic [2:0] {
        S_RESET,
        S_READY,
        S_LOAD_SEND,
        S_LOAD_WAIT,
        S_FILL,
        S_STORE_SEND,
        S_STORE_WAIT
    } state_e;

    typedef enum logic [1:0] {
        REQ_LOAD_MISS = 2'd0,
        REQ_STORE     = 2'd1,
        REQ_UC_LOAD   = 2'd2,
        REQ_UC_STORE  = 2'd3
    } req_type_e;

    localparam logic [4:0] LOAD_RQ  = 5'b00000;
    localparam logic [4:0] STORE_RQ = 5'b00001;

    localparam logic [3:0] LOAD_RET  = 4'b0000;
    localparam logic [3:0] ST_ACK    = 4'b0100;
    localparam logic [3:0] EVICT_REQ = 4'b0011;
    localparam logic [3:0] INT_RET   = 4'b0111;

    localparam logic [2:0] PCX_SZ_1B  = 3'd0;
    localparam logic [2:0] PCX_SZ_2B  = 3'd1;
    localparam logic [2:0] PCX_SZ_4B  = 3'd2;
    localparam logic [2:0] PCX_SZ_8B  = 3'd3;
    localparam logic [2:0] PCX_SZ_16B = 3'd7;

    function automatic logic [2:0] pcx_size(input logic [1:0] size);
        logic [2:0] enc;
        case (size)
            2'd0:    enc = PCX_SZ_1B;
            2'd1:    enc = PCX_SZ_2B;
            2'd2:    enc = PCX_SZ_4B;
            default: enc = PCX_SZ_8B;
        endcase
        return enc;
    endfunction

    // The L1.5 picks store bytes by address, so narrow data is copied to every lane
    function automatic logic [63:0] replicate_data(input logic [1:0] size, input logic [63:0] data);
        logic [63:0] rep;
        case (size)
            2'd0:    rep = {8{data[7:0]}};
            2'd1:    rep = {4{data[15:0]}};
            2'd2:    rep = {2{data[31:0]}};
            default: rep = data;
        endcase
        return rep;
    endfunction

endpackage

// File: rtl/bp_l15_fill_assembler.sv
// rtl/bp_l15_fill_assembler.sv - beat counter, block assembly and uncached lane extraction
module bp_l15_fill_assembler #(
    parameter int block_width_p = 512,
    parameter int fill_width_p  = 128,
    parameter int beat_width_p  = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     beat_v,
    input  logic                     cached,
    input  logic                     clear,
    input  logic [fill_width_p-1:0]  beat_data,
    input  logic [3:0]               byte_offset,
    input  logic [1:0]               size,
    output logic [block_width_p-1:0] block,
    output logic [beat_width_p-1:0]  beat,
    output logic                     last_beat,
    output logic [63:0]              lane_data
);

    localparam int nb_lp = block_width_p / fill_width_p;

    logic [fill_width_p-1:0] shifted;
    logic [63:0]             mask;

    assign last_beat = (beat == beat_width_p'(nb_lp - 1));

    // Beat counter advances on every cached return and restarts when the fill retires
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            beat <= '0;
        end else if (beat_v && cached) begin
            beat <= last_beat ? '0 : beat + 1'b1;
        end
    end

    // Each return lands in the slot selected by the current beat (slot 0 for uncached)
    always_ff @(posedge clk) begin
        if (reset) begin
            block <= '0;
        end else if (beat_v) begin
            block[beat*fill_width_p +: fill_width_p] <= beat_data;
        end
    end

    // Uncached data: right-justify the addressed bytes and zero everything above the access size
    always_comb begin
        shifted = block[fill_width_p-1:0] >> {byte_offset, 3'b000};
        case (size)
            2'd0:    mask = 64'h0000_0000_0000_00FF;
            2'd1:    mask = 64'h0000_0000_0000_FFFF;
            2'd2:    mask = 64'h0000_0000_FFFF_FFFF;
            default: mask = 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
        lane_data = shifted[63:0] & mask;
    end

endmodule

// File: rtl/bp_l15_transducer_mb.sv
// rtl/bp_l15_transducer_mb.sv - BlackParrot D-cache to OpenPiton L1.5 transducer
module bp_l15_transducer_mb
    import bp_l15_transducer_pkg::*;
#(
    parameter int paddr_width_p = 40,
    parameter int block_width_p = 512,
    parameter int fill_width_p  = 128,
    parameter int sets_p        = 64,
    parameter int assoc_p       = 8,
    parameter int ptag_width_p  = 28,
    localparam int idx_w_lp     = $clog2(sets_p),
    localparam int way_w_lp     = $clog2(assoc_p)
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     req_v_i,
    output logic                     req_ready_o,
    input  logic [1:0]               req_type_i,
    input  logic [paddr_width_p-1:0] req_addr_i,
    input  logic [way_w_lp-1:0]      req_way_i,
    input  logic [1:0]               req_size_i,
    input  logic [63:0]              req_data_i,
    output logic [4:0]               transducer_l15_rqtype,
    output logic                     transducer_l15_nc,
    output logic [2:0]               transducer_l15_size,
    output logic                     transducer_l15_val,
    output logic [39:0]              transducer_l15_address,
    output logic [63:0]              transducer_l15_data,
    output logic [1:0]               transducer_l15_l1rplway,
    input  logic                     l15_transducer_ack,
    input  logic                     l15_transducer_val,
    input  logic [3:0]               l15_transducer_returntype,
    input  logic [63:0]              l15_transducer_data_0,
    input  logic [63:0]              l15_transducer_data_1,
    input  logic [11:0]              l15_transducer_inval_address_15_4,
    input  logic [1:0]               l15_transducer_inval_way,
    output logic                     transducer_l15_req_ack,
    output logic                     data_pkt_v_o,
    input  logic                     data_pkt_yumi_i,
    output logic [idx_w_lp-1:0]      data_pkt_index_o,
    output logic [way_w_lp-1:0]      data_pkt_way_o,
    output logic [block_width_p-1:0] data_pkt_data_o,
    output logic                     tag_pkt_v_o,
    input  logic                     tag_pkt_yumi_i,
    output logic                     tag_pkt_inval_o,
    output logic [idx_w_lp-1:0]      tag_pkt_index_o,
    output logic [way_w_lp-1:0]      tag_pkt_way_o,
    output logic [ptag_width_p-1:0]  tag_pkt_tag_o,
    output logic                     stat_pkt_v_o,
    input  logic                     stat_pkt_yumi_i,
    output logic [idx_w_lp-1:0]      stat_pkt_index_o,
    output logic [way_w_lp-1:0]      stat_pkt_way_o
);

    localparam int nb_lp       = block_width_p / fill_width_p;
    localparam int beat_w_lp   = (nb_lp > 1) ? $clog2(nb_lp) : 1;
    localparam int offset_w_lp = $clog2(block_width_p / 8);

    state_e                   state, state_n;
    req_type_e                req_type;
    logic [paddr_width_p-1:0] req_addr;
    logic [way_w_lp-1:0]      req_way;
    logic [1:0]               req_size;
    logic [63:0]              req_data;
    logic                     inval_pending;
    logic [idx_w_lp-1:0]      inval_index;
    logic [1:0]               inval_way;
    logic                     data_done, tag_done, stat_done;

    logic                     accept, evict_take, beat_v, fill_done, cached, uncached;
    logic [15:0]              inval_addr_full;
    logic [idx_w_lp-1:0]      req_index;
    logic [block_width_p-1:0] block;
    logic [beat_w_lp-1:0]     beat;
    logic                     last_beat;
    logic [63:0]              lane_data;

    assign cached          = (req_type == REQ_LOAD_MISS);
    assign uncached        = (req_type == REQ_UC_LOAD) || (req_type == REQ_UC_STORE);
    assign accept          = req_v_i & req_ready_o;
    assign evict_take      = (state != S_RESET) & l15_transducer_val
                           & (l15_transducer_returntype == EVICT_REQ) & ~inval_pending;
    assign inval_addr_full = {l15_transducer_inval_address_15_4, 4'b0000};
    assign req_index       = req_addr[6 +: idx_w_lp];

    assign data_pkt_index_o = req_index;
    assign data_pkt_way_o   = req_way;
    assign data_pkt_data_o  = cached ? block : block_width_p'(lane_data);
    assign stat_pkt_index_o = req_index;
    assign stat_pkt_way_o   = req_way;
    assign transducer_l15_l1rplway = req_way[1:0];

    bp_l15_fill_assembler #(
        .block_width_p(block_width_p),
        .fill_width_p (fill_width_p),
        .beat_width_p (beat_w_lp)
    ) u_fill (
        .clk        (clk_i),
        .reset      (reset_i),
        .beat_v     (beat_v),
        .cached     (cached),
        .clear      (fill_done),
        .beat_data  ({l15_transducer_data_1, l15_transducer_data_0}),
        .byte_offset(req_addr[3:0]),
        .size       (req_size),
        .block      (block),
        .beat       (beat),
        .last_beat  (last_beat),
        .lane_data  (lane_data)
    );

    // State register
    always_ff @(posedge clk_i) begin
        if (reset_i) state <= S_RESET;
        else         state <= state_n;
    end

    // Request latch, one-entry invalidation buffer and per-packet done bits
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            req_type      <= REQ_LOAD_MISS;
            req_addr      <= '0;
            req_way       <= '0;
            req_size      <= '0;
            req_data      <= '0;
            inval_pending <= 1'b0;
            inval_index   <= '0;
            inval_way     <= '0;
            data_done     <= 1'b0;
            tag_done      <= 1'b0;
            stat_done     <= 1'b0;
        end else begin
            if (accept) begin
                req_type <= req_type_e'(req_type_i);
                req_addr <= req_addr_i;
                req_way  <= req_way_i;
                req_size <= req_size_i;
                req_data <= req_data_i;
            end
            if (evict_take) begin
                inval_pending <= 1'b1;
                inval_index   <= inval_addr_full[6 +: idx_w_lp];
                inval_way     <= l15_transducer_inval_way;
            end else if (state == S_READY && inval_pending && tag_pkt_yumi_i) begin
                inval_pending <= 1'b0;
            end
            if (state == S_FILL) begin
                if (fill_done) begin
                    data_done <= 1'b0;
                    tag_done  <= 1'b0;
                    stat_done <= 1'b0;
                end else begin
                    data_done <= data_done | (data_pkt_v_o & data_pkt_yumi_i);
                    tag_done  <= tag_done  | (tag_pkt_v_o  & tag_pkt_yumi_i);
                    stat_done <= stat_done | (stat_pkt_v_o & stat_pkt_yumi_i);
                end
            end
        end
    end

    // Next state, L1.5 request fields, return acks and packet valids
    always_comb begin
        state_n                = state;
        req_ready_o            = 1'b0;
        transducer_l15_val     = 1'b0;
        transducer_l15_rqtype  = LOAD_RQ;
        transducer_l15_nc      = 1'b0;
        transducer_l15_size    = PCX_SZ_1B;
        transducer_l15_address = '0;
        transducer_l15_data    = '0;
        transducer_l15_req_ack = 1'b0;
        beat_v                 = 1'b0;
        fill_done              = 1'b0;
        data_pkt_v_o           = 1'b0;
        tag_pkt_v_o            = 1'b0;
        tag_pkt_inval_o        = 1'b0;
        tag_pkt_index_o        = req_index;
        tag_pkt_way_o          = req_way;
        tag_pkt_tag_o          = req_addr[paddr_width_p-1 -: ptag_width_p];
        stat_pkt_v_o           = 1'b0;

        case (state)
            S_RESET: begin
                if (l15_transducer_val && l15_transducer_returntype == INT_RET) begin
                    transducer_l15_req_ack = 1'b1;
                    state_n                = S_READY;
                end
            end
            S_READY: begin
                req_ready_o = ~inval_pending;
                if (inval_pending) begin
                    tag_pkt_v_o     = 1'b1;
                    tag_pkt_inval_o = 1'b1;
                    tag_pkt_index_o = inval_index;
                    tag_pkt_way_o   = way_w_lp'(inval_way);
                    tag_pkt_tag_o   = '0;
                end else if (req_v_i) begin
                    if (req_type_i == REQ_LOAD_MISS || req_type_i == REQ_UC_LOAD)
                        state_n = S_LOAD_SEND;
                    else
                        state_n = S_STORE_SEND;
                end
            end
            S_LOAD_SEND: begin
                transducer_l15_val    = 1'b1;
                transducer_l15_rqtype = LOAD_RQ;
                transducer_l15_nc     = uncached;
                if (cached) begin
                    transducer_l15_size    = PCX_SZ_16B;
                    transducer_l15_address = {req_addr[paddr_width_p-1:offset_w_lp], {offset_w_lp{1'b0}}}
                                           + (paddr_width_p'(beat) << 4);
                end else begin
                    transducer_l15_size    = pcx_size(req_size);
                    transducer_l15_address = req_addr;
                end
                if (l15_transducer_ack) state_n = S_LOAD_WAIT;
            end
            S_LOAD_WAIT: begin
                if (l15_transducer_val && l15_transducer_returntype == LOAD_RET) begin
                    transducer_l15_req_ack = 1'b1;
                    beat_v                 = 1'b1;
                    if (cached && !last_beat) state_n = S_LOAD_SEND;
                    else                      state_n = S_FILL;
                end
            end
            S_FILL: begin
                data_pkt_v_o = ~data_done;
                if (cached) begin
                    tag_pkt_v_o  = ~tag_done;
                    stat_pkt_v_o = ~stat_done;
                    fill_done    = (data_done | data_pkt_yumi_i) & (tag_done | tag_pkt_yumi_i)
                                 & (stat_done | stat_pkt_yumi_i);
                end else begin
                    fill_done    = data_done | data_pkt_yumi_i;
                end
                if (fill_done) state_n = S_READY;
            end
            S_STORE_SEND: begin
                transducer_l15_val     = 1'b1;
                transducer_l15_rqtype  = STORE_RQ;
                transducer_l15_nc      = uncached;
                transducer_l15_size    = pcx_size(req_size);
                transducer_l15_address = req_addr;
                transducer_l15_data    = replicate_data(req_size, req_data);
                if (l15_transducer_ack) state_n = S_STORE_WAIT;
            end
            S_STORE_WAIT: begin
                if (l15_transducer_val && l15_transducer_returntype == ST_ACK) begin
                    transducer_l15_req_ack = 1'b1;
                    state_n                = S_READY;
                end
            end
            default: state_n = S_RESET;
        endcase

        if (evict_take) transducer_l15_req_ack = 1'b1;
    end

endmodule

// File: tb/tb_bp_l15_transducer_mb.sv
// tb/tb_bp_l15_transducer_mb.sv - scoreboard bench for the BP/L1.5 transducer
module tb_bp_l15_transducer_mb;

    localparam logic [3:0] RT_LOAD  = 4'b0000;
    localparam logic [3:0] RT_STACK = 4'b0100;
    localparam logic [3:0] RT_EVICT = 4'b0011;
    localparam logic [3:0] RT_INT   = 4'b0111;

    logic         clk = 1'b0;
    logic         reset_i;
    logic         req_v_i, req_ready_o;
    logic [1:0]   req_type_i, req_size_i;
    logic [39:0]  req_addr_i;
    logic [2:0]   req_way_i;
    logic [63:0]  req_data_i;
    logic [4:0]   transducer_l15_rqtype;
    logic         transducer_l15_nc, transducer_l15_val;
    logic [2:0]   transducer_l15_size;
    logic [39:0]  transducer_l15_address;
    logic [63:0]  transducer_l15_data;
    logic [1:0]   transducer_l15_l1rplway;
    logic         l15_transducer_ack, l15_transducer_val;
    logic [3:0]   l15_transducer_returntype;
    logic [63:0]  l15_transducer_data_0, l15_transducer_data_1;
    logic [11:0]  l15_transducer_inval_address_15_4;
    logic [1:0]   l15_transducer_inval_way;
    logic         transducer_l15_req_ack;
    logic         data_pkt_v_o, data_pkt_yumi_i;
    logic [5:0]   data_pkt_index_o, tag_pkt_index_o, stat_pkt_index_o;
    logic [2:0]   data_pkt_way_o, tag_pkt_way_o, stat_pkt_way_o;
    logic [511:0] data_pkt_data_o;
    logic         tag_pkt_v_o, tag_pkt_yumi_i, tag_pkt_inval_o;
    logic [27:0]  tag_pkt_tag_o;
    logic         stat_pkt_v_o, stat_pkt_yumi_i;

    typedef struct packed {
        logic [4:0]  rqtype;
        logic        nc;
        logic [2:0]  size;
        logic [39:0] addr;
        logic [63:0] data;
        logic [1:0]  way;
    } l15_req_t;

    l15_req_t     req_q[$];
    logic [511:0] pkt_q[$];
    int           checks = 0;
    int           errors = 0;

    bp_l15_transducer_mb dut (
        .clk_i(clk), .reset_i(reset_i),
        .req_v_i(req_v_i), .req_ready_o(req_ready_o), .req_type_i(req_type_i),
        .req_addr_i(req_addr_i), .req_way_i(req_way_i), .req_size_i(req_size_i), .req_data_i(req_data_i),
        .transducer_l15_rqtype(transducer_l15_rqtype), .transducer_l15_nc(transducer_l15_nc),
        .transducer_l15_size(transducer_l15_size), .transducer_l15_val(transducer_l15_val),
        .transducer_l15_address(transducer_l15_address), .transducer_l15_data(transducer_l15_data),
        .transducer_l15_l1rplway(transducer_l15_l1rplway), .l15_transducer_ack(l15_transducer_ack),
        .l15_transducer_val(l15_transducer_val), .l15_transducer_returntype(l15_transducer_returntype),
        .l15_transducer_data_0(l15_transducer_data_0), .l15_transducer_data_1(l15_transducer_data_1),
        .l15_transducer_inval_address_15_4(l15_transducer_inval_address_15_4),
        .l15_transducer_inval_way(l15_transducer_inval_way), .transducer_l15_req_ack(transducer_l15_req_ack),
        .data_pkt_v_o(data_pkt_v_o), .data_pkt_yumi_i(data_pkt_yumi_i), .data_pkt_index_o(data_pkt_index_o),
        .data_pkt_way_o(data_pkt_way_o), .data_pkt_data_o(data_pkt_data_o),
        .tag_pkt_v_o(tag_pkt_v_o), .tag_pkt_yumi_i(tag_pkt_yumi_i), .tag_pkt_inval_o(tag_pkt_inval_o),
        .tag_pkt_index_o(tag_pkt_index_o), .tag_pkt_way_o(tag_pkt_way_o), .tag_pkt_tag_o(tag_pkt_tag_o),
        .stat_pkt_v_o(stat_pkt_v_o), .stat_pkt_yumi_i(stat_pkt_yumi_i),
        .stat_pkt_index_o(stat_pkt_index_o), .stat_pkt_way_o(stat_pkt_way_o)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1);
    end

    task automatic expect_eq(input string tag, input logic [511:0] got, input logic [511:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] rep_model(input int sz, input logic [63:0] d);
        logic [63:0] r;
        int w;
        w = 8 << sz;
        for (int i = 0; i < 64; i++) r[i] = d[i % w];
        return r;
    endfunction

    function automatic logic [63:0] lane_model(input logic [127:0] beat, input int off, input int sz);
        logic [127:0] m;
        m = (128'd1 << (8 << sz)) - 128'd1;
        return 64'((beat >> (8 * off)) & m);
    endfunction

    function automatic logic [5:0] inval_idx_model(input logic [11:0] a);
        logic [15:0] full;
        full = {a, 4'h0};
        return 6'((full >> 6) & 16'h3F);
    endfunction

    function automatic l15_req_t mk_req(input logic [4:0] rq, input logic nc, input logic [2:0] sz,
                                        input logic [39:0] a, input logic [63:0] d, input logic [2:0] way);
        l15_req_t r;
        r.rqtype = rq; r.nc = nc; r.size = sz; r.addr = a; r.data = d; r.way = 2'(way % 4);
        return r;
    endfunction

    task automatic push_cached_reqs(input logic [39:0] a, input logic [2:0] way);
        for (int i = 0; i < 4; i++)
            req_q.push_back(mk_req(5'b00000, 1'b0, 3'd7, (a & ~40'h3F) + 40'(16 * i), 64'h0, way));
    endtask

    task automatic bp_req(input logic [1:0] t, input logic [39:0] a, input logic [2:0] way,
                          input logic [1:0] sz, input logic [63:0] d);
        int n;
        n = 0;
        while (!req_ready_o && n < 40) begin @(negedge clk); #1; n++; end
        expect_eq("bp_req_ready", req_ready_o, 1);
        req_v_i = 1; req_type_i = t; req_addr_i = a; req_way_i = way; req_size_i = sz; req_data_i = d;
        @(negedge clk);
        req_v_i = 0; req_type_i = ~t; req_addr_i = ~a; req_way_i = ~way; req_size_i = ~sz; req_data_i = ~d;
        #1;
    endtask

    task automatic serve_req();
        l15_req_t e;
        int n;
        n = 0;
        while (!transducer_l15_val && n < 40) begin @(negedge clk); #1; n++; end
        expect_eq("l15_req_val", transducer_l15_val, 1);
        expect_eq("l15_req_expected", req_q.size() != 0, 1);
        if (req_q.size() == 0) return;
        e = req_q.pop_front();
        @(negedge clk); #1;
        expect_eq("l15_req_hold", transducer_l15_val, 1);
        expect_eq("l15_rqtype", transducer_l15_rqtype, e.rqtype);
        expect_eq("l15_nc", transducer_l15_nc, e.nc);
        expect_eq("l15_size", transducer_l15_size, e.size);
        expect_eq("l15_address", transducer_l15_address, e.addr);
        expect_eq("l15_data", transducer_l15_data, e.data);
        expect_eq("l15_rplway", transducer_l15_l1rplway, e.way);
        l15_transducer_ack = 1;
        @(negedge clk);
        l15_transducer_ack = 0;
        #1;
        expect_eq("l15_req_drop", transducer_l15_val, 0);
    endtask

    task automatic send_return(input string tag, input logic [3:0] rt, input logic [63:0] d0,
                               input logic [63:0] d1, input logic exp_ack);
        l15_transducer_val = 1; l15_transducer_returntype = rt;
        l15_transducer_data_0 = d0; l15_transducer_data_1 = d1;
        #1;
        expect_eq(tag, transducer_l15_req_ack, exp_ack);
        @(negedge clk);
        l15_transducer_val = 0;
        #1;
    endtask

    task automatic wait_data_pkt();
        int n;
        n = 0;
        while (!data_pkt_v_o && n < 40) begin @(negedge clk); #1; n++; end
        expect_eq("data_pkt_v", data_pkt_v_o, 1);
        expect_eq("data_pkt_expected", pkt_q.size() != 0, 1);
        if (pkt_q.size() != 0) expect_eq("data_pkt_data", data_pkt_data_o, pkt_q.pop_front());
    endtask

    task automatic pulse_yumi(input int which);
        if (which == 0) data_pkt_yumi_i = 1;
        if (which == 1) tag_pkt_yumi_i = 1;
        if (which == 2) stat_pkt_yumi_i = 1;
        @(negedge clk);
        data_pkt_yumi_i = 0; tag_pkt_yumi_i = 0; stat_pkt_yumi_i = 0;
        #1;
    endtask

    task automatic fill_cached(input logic [39:0] a, input logic [2:0] way);
        wait_data_pkt();
        expect_eq("fill_tag_v", tag_pkt_v_o, 1);
        expect_eq("fill_stat_v", stat_pkt_v_o, 1);
        expect_eq("fill_tag_inval", tag_pkt_inval_o, 0);
        expect_eq("fill_data_index", data_pkt_index_o, (a >> 6) % 64);
        expect_eq("fill_data_way", data_pkt_way_o, way);
        expect_eq("fill_tag_index", tag_pkt_index_o, (a >> 6) % 64);
        expect_eq("fill_tag_way", tag_pkt_way_o, way);
        expect_eq("fill_tag", tag_pkt_tag_o, a >> 12);
        expect_eq("fill_stat_index", stat_pkt_index_o, (a >> 6) % 64);
        expect_eq("fill_stat_way", stat_pkt_way_o, way);
        expect_eq("fill_ready", req_ready_o, 0);
        pulse_yumi(0);
        expect_eq("after_data_yumi", {data_pkt_v_o, tag_pkt_v_o, stat_pkt_v_o}, 3'b011);
        pulse_yumi(2);
        expect_eq("after_stat_yumi", {data_pkt_v_o, tag_pkt_v_o, stat_pkt_v_o}, 3'b010);
        pulse_yumi(1);
    endtask

    task automatic cached_load(input logic [39:0] a, input logic [2:0] way, input int evict_at);
        logic [511:0] blk;
        logic [63:0]  d0, d1;
        blk = '0;
        push_cached_reqs(a, way);
        bp_req(2'd0, a, way, 2'd3, 64'h0);
        for (int i = 0; i < 4; i++) begin
            serve_req();
            if (i == evict_at)
                send_return("evict_ack", RT_EVICT, 64'h0, 64'h0, 1'b1);
            d0 = 64'hA + 64'(i) + 64'(a[15:8]);
            d1 = {32'(i + 1), 32'h5A5A_0000 ^ 32'($urandom)};
            blk[i*128 +: 128] = {d1, d0};
            send_return("load_ret_ack", RT_LOAD, d0, d1, 1'b1);
        end
        pkt_q.push_back(blk);
    endtask

    initial begin
        logic [63:0]  d0, d1, sd;
        logic [39:0]  sa;
        logic [1:0]   st;

        reset_i = 1; req_v_i = 0; req_type_i = 0; req_addr_i = 0; req_way_i = 0; req_size_i = 0; req_data_i = 0;
        l15_transducer_ack = 0; l15_transducer_val = 0; l15_transducer_returntype = 0;
        l15_transducer_data_0 = 0; l15_transducer_data_1 = 0;
        l15_transducer_inval_address_15_4 = 0; l15_transducer_inval_way = 0;
        data_pkt_yumi_i = 0; tag_pkt_yumi_i = 0; stat_pkt_yumi_i = 0;
        repeat (2) @(negedge clk);
        #1;
        expect_eq("reset_valids", {req_ready_o, transducer_l15_val, transducer_l15_req_ack,
                                   data_pkt_v_o, tag_pkt_v_o, stat_pkt_v_o}, 6'b0);
        reset_i = 0;
        @(negedge clk); #1;
        expect_eq("reset_state_ready", req_ready_o, 0);
        send_return("reset_load_ret_nack", RT_LOAD, 64'h1, 64'h2, 1'b0);
        send_return("int_ret_ack", RT_INT, 64'h0, 64'h0, 1'b1);
        expect_eq("ready_after_int", req_ready_o, 1);

        // cached miss with an eviction arriving mid-fill
        l15_transducer_inval_address_15_4 = 12'h041; l15_transducer_inval_way = 2'd2;
        cached_load(40'h80001040, 3'd5, 2);
        l15_transducer_inval_address_15_4 = 12'h104; l15_transducer_inval_way = 2'd3;
        l15_transducer_returntype = RT_EVICT; l15_transducer_val = 1;
        #1;
        expect_eq("evict_pending_nack", transducer_l15_req_ack, 0);
        fill_cached(40'h80001040, 3'd5);
        expect_eq("inval1_tag_v", tag_pkt_v_o, 1);
        expect_eq("inval1_inval", tag_pkt_inval_o, 1);
        expect_eq("inval1_index", tag_pkt_index_o, inval_idx_model(12'h041));
        expect_eq("inval1_way", tag_pkt_way_o, 2);
        expect_eq("inval1_ready", req_ready_o, 0);
        expect_eq("inval1_data_v", data_pkt_v_o, 0);
        expect_eq("inval1_held_nack", transducer_l15_req_ack, 0);
        pulse_yumi(1);
        expect_eq("evict2_ack", transducer_l15_req_ack, 1);
        @(negedge clk);
        l15_transducer_val = 0;
        #1;
        expect_eq("inval2_tag_v", tag_pkt_v_o, 1);
        expect_eq("inval2_inval", tag_pkt_inval_o, 1);
        expect_eq("inval2_index", tag_pkt_index_o, inval_idx_model(12'h104));
        expect_eq("inval2_way", tag_pkt_way_o, 3);
        expect_eq("inval2_ready", req_ready_o, 0);
        pulse_yumi(1);
        expect_eq("inval2_cleared", {tag_pkt_v_o, req_ready_o}, 2'b01);

        // uncached 2B load; high half carries junk that must be masked off
        req_q.push_back(mk_req(5'b00000, 1'b1, 3'd1, 40'h80000006, 64'h0, 3'd0));
        bp_req(2'd2, 40'h80000006, 3'd0, 2'd1, 64'h0);
        serve_req();
        d0 = 64'h1122334455667788; d1 = 64'hCAFEF00D12345678;
        pkt_q.push_back(512'(lane_model({d1, d0}, 6, 1)));
        send_return("uc_load_ack", RT_LOAD, d0, d1, 1'b1);
        wait_data_pkt();
        expect_eq("uc_no_tag_stat", {tag_pkt_v_o, stat_pkt_v_o}, 2'b00);
        pulse_yumi(0);
        expect_eq("uc_done", {data_pkt_v_o, req_ready_o}, 2'b01);

        // stores of every size, cached and uncached alternately
        for (int s = 0; s < 4; s++) begin
            sa = 40'h80000003 + 40'(s * 16);
            sd = (s == 0) ? 64'hAB : {32'($urandom), 32'($urandom)};
            st = (s % 2 == 1) ? 2'd3 : 2'd1;
            req_q.push_back(mk_req(5'b00001, s % 2 == 1, 3'(s), sa, rep_model(s, sd), 3'(s)));
            bp_req(st, sa, 3'(s), 2'(s), sd);
            serve_req();
            send_return("store_wait_load_nack", RT_LOAD, 64'h0, 64'h0, 1'b0);
            send_return("st_ack", RT_STACK, 64'h0, 64'h0, 1'b1);
            expect_eq("store_ready", req_ready_o, 1);
        end

        // reset while waiting on beat 2, then a full miss must restart at beat 0
        push_cached_reqs(40'h80002080, 3'd3);
        bp_req(2'd0, 40'h80002080, 3'd3, 2'd3, 64'h0);
        for (int i = 0; i < 2; i++) begin
            serve_req();
            send_return("pre_reset_beat_ack", RT_LOAD, 64'(i), 64'(i), 1'b1);
        end
        serve_req();
        reset_i = 1;
        @(negedge clk);
        reset_i = 0;
        #1;
        expect_eq("midreset_valids", {req_ready_o, transducer_l15_val, data_pkt_v_o, tag_pkt_v_o, stat_pkt_v_o}, 5'b0);
        req_q.delete();
        send_return("midreset_load_nack", RT_LOAD, 64'h0, 64'h0, 1'b0);
        send_return("midreset_int_ack", RT_INT, 64'h0, 64'h0, 1'b1);
        cached_load(40'h80002080, 3'd3, -1);
        fill_cached(40'h80002080, 3'd3);
        expect_eq("final_ready", req_ready_o, 1);
        expect_eq("req_q_drained", req_q.size(), 0);
        expect_eq("pkt_q_drained", pkt_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
